// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default operand width and small op-decode helpers.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL     = 3'd1,
    ST_ACC     = 3'd2,
    ST_DIV_RUN = 3'd3,
    ST_DIV_FIX = 3'd4,
    ST_DONE    = 3'd5
  } muldiv_state_e;

  // Even encodings are the signed variants.
  function automatic logic op_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_acc(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider. A start pulse captures the raw operands; the
// first busy cycle converts them to magnitudes, then WIDTH cycles each retire
// one quotient bit. ready_o marks the final iteration cycle, so quotient_o and
// remainder_o (sign-corrected) are valid from the following cycle on.
module muldiv_div_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             annul_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             ready_o
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_raw, b_raw;
  logic             sgn;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic             neg_q, neg_r;

  logic [WIDTH:0]   trial_rem, trial_diff;
  logic [WIDTH-1:0] step_quo, step_rem;

  // Two's-complement magnitude; MIN maps onto itself, which reads correctly
  // as the unsigned value 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  always_comb begin
    trial_rem  = {rem, quo[WIDTH-1]};
    trial_diff = trial_rem - {1'b0, dvs};
    step_rem   = trial_rem[WIDTH-1:0];
    step_quo   = {quo[WIDTH-2:0], 1'b0};
    if (!trial_diff[WIDTH]) begin
      step_rem = trial_diff[WIDTH-1:0];
      step_quo = {quo[WIDTH-2:0], 1'b1};
    end
  end

  // Operand capture, magnitude load and iteration down-counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      a_raw <= '0;
      b_raw <= '0;
      sgn   <= 1'b0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (annul_i) begin
      cnt <= '0;
    end else if (start_i) begin
      a_raw <= dividend_i;
      b_raw <= divisor_i;
      sgn   <= signed_i;
      cnt   <= CNT_LOAD;
    end else if (cnt == CNT_LOAD) begin
      quo   <= magnitude(a_raw, sgn);
      dvs   <= magnitude(b_raw, sgn);
      rem   <= '0;
      neg_q <= sgn & (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
      neg_r <= sgn & a_raw[WIDTH-1];
      cnt   <= cnt - 1'b1;
    end else if (cnt != '0) begin
      quo <= step_quo;
      rem <= step_rem;
      cnt <= cnt - 1'b1;
    end
  end

  assign ready_o = (cnt == CNT_LAST);

  // Quotient sign follows the operand signs, remainder follows the dividend.
  // MIN / -1 yields a positive magnitude 2^(WIDTH-1) that reads back as MIN.
  assign quotient_o  = neg_q ? (~quo + 1'b1) : quo;
  assign remainder_o = neg_r ? (~rem + 1'b1) : rem;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply / multiply-accumulate / divide unit beside the ALU.
// Holds the pipeline via stall_req_o while busy and issues a one-cycle HI/LO
// write in DONE. Define MULDIV_ACCUM_EN to build the MADD/MSUB family;
// without it those ops complete immediately as no-writes.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             annul_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic             stall_req_o,
  output logic             done_o,
  output logic             hilo_we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  muldiv_state_e state, state_nxt;

  logic             launch;
  logic             div_start;
  logic             sgn_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             we_r;
  logic             dbz_r;

  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, product;

  logic [WIDTH-1:0] div_quo, div_rem;
  logic             div_ready;

`ifdef MULDIV_ACCUM_EN
  logic               acc_r, sub_r;
  logic [WIDTH-1:0]   acc_hi_r, acc_lo_r;
  logic [2*WIDTH-1:0] acc_base, acc_result;
`else
  logic               unused_acc;
  assign unused_acc = ^{hi_i, lo_i};
`endif

  // annul_i outranks start_i, so a flushed instruction never launches.
  assign launch    = start_i & ~annul_i;
  assign div_start = (state == ST_IDLE) & launch & op_is_div(op_i) & (opb_i != '0);

  assign mul_a_ext = {{WIDTH{sgn_r & a_r[WIDTH-1]}}, a_r};
  assign mul_b_ext = {{WIDTH{sgn_r & b_r[WIDTH-1]}}, b_r};
  assign product   = mul_a_ext * mul_b_ext;

`ifdef MULDIV_ACCUM_EN
  // The MUL state parks the product in {hi_r, lo_r}; ACC folds it into the
  // captured HI/LO.
  assign acc_base   = {acc_hi_r, acc_lo_r};
  assign acc_result = sub_r ? (acc_base - {hi_r, lo_r}) : (acc_base + {hi_r, lo_r});
`endif

  muldiv_div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .annul_i    (annul_i),
    .signed_i   (op_is_signed(op_i)),
    .dividend_i (opa_i),
    .divisor_i  (opb_i),
    .quotient_o (div_quo),
    .remainder_o(div_rem),
    .ready_o    (div_ready)
  );

  // State register plus operand capture and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      sgn_r <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      we_r  <= 1'b0;
      dbz_r <= 1'b0;
`ifdef MULDIV_ACCUM_EN
      acc_r    <= 1'b0;
      sub_r    <= 1'b0;
      acc_hi_r <= '0;
      acc_lo_r <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            sgn_r <= op_is_signed(op_i);
            a_r   <= opa_i;
            b_r   <= opb_i;
            hi_r  <= '0;
            lo_r  <= '0;
            dbz_r <= op_is_div(op_i) & (opb_i == '0);
`ifdef MULDIV_ACCUM_EN
            we_r     <= 1'b1;
            acc_r    <= op_is_acc(op_i);
            sub_r    <= op_is_sub(op_i);
            acc_hi_r <= hi_i;
            acc_lo_r <= lo_i;
`else
            we_r  <= ~op_is_acc(op_i);
`endif
          end
        end
        ST_MUL: {hi_r, lo_r} <= product;
`ifdef MULDIV_ACCUM_EN
        ST_ACC: {hi_r, lo_r} <= acc_result;
`endif
        ST_DIV_FIX: begin
          hi_r <= div_rem;
          lo_r <= div_quo;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and output strobes.
  always_comb begin
    state_nxt     = state;
    stall_req_o   = 1'b0;
    done_o        = 1'b0;
    hilo_we_o     = 1'b0;
    hi_o          = '0;
    lo_o          = '0;
    div_by_zero_o = 1'b0;

    case (state)
      ST_IDLE: begin
        if (launch) begin
          stall_req_o = 1'b1;
          if (op_is_div(op_i)) begin
            state_nxt = (opb_i == '0) ? ST_DONE : ST_DIV_RUN;
          end else if (op_is_acc(op_i)) begin
`ifdef MULDIV_ACCUM_EN
            state_nxt = ST_MUL;
`else
            state_nxt = ST_DONE;
`endif
          end else begin
            state_nxt = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        stall_req_o = 1'b1;
`ifdef MULDIV_ACCUM_EN
        state_nxt = acc_r ? ST_ACC : ST_DONE;
`else
        state_nxt = ST_DONE;
`endif
      end
`ifdef MULDIV_ACCUM_EN
      ST_ACC: begin
        stall_req_o = 1'b1;
        state_nxt   = ST_DONE;
      end
`endif
      ST_DIV_RUN: begin
        stall_req_o = 1'b1;
        if (div_ready) state_nxt = ST_DIV_FIX;
      end
      ST_DIV_FIX: begin
        stall_req_o = 1'b1;
        state_nxt   = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        if (!annul_i) begin
          done_o        = 1'b1;
          hilo_we_o     = we_r;
          hi_o          = hi_r;
          lo_o          = lo_r;
          div_by_zero_o = dbz_r;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (state != ST_IDLE && annul_i) state_nxt = ST_IDLE;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit that sits beside the execute-stage ALU. It computes 2·WIDTH-bit HI/LO results for signed/unsigned multiply, multiply-accumulate/subtract and iterative divide. It holds the pipeline with a stall request while busy and delivers a one-cycle HI/LO write strobe toward the MEM stage.

## Interface
- WIDTH, 32, operand and HI/LO register width (≥4, even)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- start_i  in  1  launch op; sampled only in IDLE
- annul_i  in  1  pipeline flush; aborts current op
- op_i  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
- opa_i  in  WIDTH  rs operand (multiplicand / dividend)
- opb_i  in  WIDTH  rt operand (multiplier / divisor)
- hi_i, lo_i  in  WIDTH  current (forwarded) HI/LO, used by accumulate ops
- stall_req_o  out  1  pipeline hold request
- done_o  out  1  result valid, one cycle
- hilo_we_o  out  1  HI/LO write enable, coincident with done_o
- hi_o, lo_o  out  WIDTH  result to HI/LO
- div_by_zero_o  out  1  set with done_o when DIV/DIVU divisor was 0

## Operation
- States: IDLE, MUL, ACC, DIV_RUN, DIV_FIX, DONE.
- Reset (rst low at an edge): state IDLE, counter 0; all outputs 0. Applies mid-operation; no write is issued.
- IDLE + start_i: operands, op and (for accumulate) hi_i/lo_i captured. MULT/MULTU → MUL; MADD*/MSUB* → MUL; DIV/DIVU with opb_i≠0 → DIV_RUN; divisor 0 → DONE with zero result.
- MUL: full 2·WIDTH product registered (signed: sign-extended operands; unsigned: zero-extended). MULT* → DONE, accumulate → ACC.
- ACC: {hi,lo} ± product, modulo 2^(2·WIDTH), → DONE.
- DIV_RUN: restoring divide on magnitudes (signed ops take two's-complement absolute value), one quotient bit per cycle, WIDTH cycles, → DIV_FIX.
- DIV_FIX: quotient negated if sign(a)≠sign(b); remainder takes sign of dividend. LO=quotient, HI=remainder. MIN/−1: LO=MIN, HI=0 (wrap, no trap). → DONE.
- DONE: done_o=hilo_we_o=1, hi_o/lo_o valid, → IDLE. Outputs return to 0 the next cycle.
- start_i outside IDLE is ignored; op_i/opa_i/opb_i may change after launch.
- annul_i in any state except IDLE: → IDLE next edge, no done_o/hilo_we_o. annul_i concurrent with start_i in IDLE: no launch. annul_i in DONE suppresses the write.
- rst takes priority over annul_i, which takes priority over start_i.

## Timing
- Launch cycle N (IDLE, start_i=1).
- stall_req_o = (IDLE & start_i & ~annul_i) | state∈{MUL, ACC, DIV_RUN, DIV_FIX}; combinational; 0 in DONE, so the pipeline advances on the write cycle.
- MULT/MULTU: done at N+2. MADD/MSUB family: done at N+3.
- DIV/DIVU: done at N+WIDTH+3 (N+35 for WIDTH=32). Divide by zero: done at N+1.
- Next launch is accepted at the cycle after DONE at the earliest.

## Configuration
- MULDIV_ACCUM_EN defined: ops 4–7 implemented as above; ACC state and hi_i/lo_i capture exist.
- Undefined: ACC state, hi_i/lo_i registers and adder removed. Ops 4–7 go straight to DONE at N+1 with hilo_we_o=0 and done_o=1 (illegal-op no-op). hi_i/lo_i are unused.

## Structure
- Shared package muldiv_pkg: op_i encodings, state enum, default WIDTH.
- Sub-module muldiv_div_core: magnitude conversion, WIDTH-step restoring iterator and sign fixup, driven by start/annul and returning quotient, remainder and ready. The multiplier and accumulator stay in muldiv_unit.

## Test plan
- DIV 7 / −2 (0xFFFFFFFE) → done at N+35, LO=0xFFFFFFFD, HI=0x00000001, stall_req_o high N..N+34.
- DIVU 0xFFFFFFFF / 0x10 → LO=0x0FFFFFFF, HI=0xF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV 5 / 0 → done at N+1, div_by_zero_o=1, HI=LO=0, hilo_we_o=1.
- MULT 0x80000000 × 2 → done N+2, HI=0xFFFFFFFF, LO=0. MULTU same operands → HI=1, LO=0.
- MADDU with hi_i=0, lo_i=0xFFFFFFFF, opa=opb=1 → done N+3, HI=1, LO=0. MSUB with HI:LO=0:0, 1×1 → HI=LO=0xFFFFFFFF. Macro off: same stimulus → done N+1, hilo_we_o=0.
- annul_i at N+10 of a DIV → IDLE at N+11, no write, new MULT launched at N+11 completes normally. rst low at N+5 of a DIV → all outputs 0, no write.
